// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   state_t     : fetch control state (RUN issues requests, HALT waits for a redirect)
//   INSTR_BYTES : byte distance between consecutive fetch addresses
//   entry_t     : one buffered fetch result as presented to decode
`ifndef ALEN
`define ALEN 32
`endif
`ifndef ILEN
`define ILEN 32
`endif

package ifetch_types;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [`ILEN-1:0] data;
    logic             fault;
    logic [`ALEN-1:0] addr;
  } entry_t;

endpackage

// File: rtl/ifetch_queue.sv
// Synchronous FIFO holding fetched words until decode takes them.
//   clk, rst     : clock, synchronous active-high reset (pointers/count only)
//   push, din    : write din at the tail (ignored when full unless popping)
//   pop          : drop the head (ignored when empty)
//   clear        : empty the queue; wins over push and pop
//   head         : current head entry, valid when !empty
//   count/empty/full : occupancy
module ifetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clear,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  // DEPTH need not be a power of two here, so wrap by compare.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty  = (count_q == '0);
  assign full   = (count_q == CNT_W'(DEPTH));
  assign count  = count_q;
  assign head   = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/ifetch.sv
// Instruction-fetch stage feeding decode.
//   clk, rst            : clock, synchronous active-high reset
//   flush, flush_target : redirect; target becomes the new PC
//   next_stalled        : decode cannot accept this cycle
//   stall_next          : no valid entry presented this cycle
//   instruction, instruction_addr, instruction_next_addr, ifetch_exception : head entry
//   mem_req_*           : aligned fetch request channel (valid/ready)
//   mem_resp_*          : in-order fetch responses, at most one per cycle
module ifetch
  import ifetch_types::*;
#(
  parameter logic [`ALEN-1:0] RESET_PC     = '0,
  parameter int               MAX_INFLIGHT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [`ALEN-1:0] flush_target,
  input  logic             next_stalled,
  output logic             stall_next,
  output logic [`ILEN-1:0] instruction,
  output logic [`ALEN-1:0] instruction_addr,
  output logic [`ALEN-1:0] instruction_next_addr,
  output logic             ifetch_exception,
  output logic             mem_req_valid,
  output logic [`ALEN-1:0] mem_req_addr,
  input  logic             mem_req_ready,
  input  logic             mem_resp_valid,
  input  logic [`ILEN-1:0] mem_resp_data,
  input  logic             mem_resp_fault
);

  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

  state_t           state_q, state_d;
  logic [`ALEN-1:0] pc_q, pc_d;
  logic [`ALEN-1:0] resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             misalign_q, misalign_d;

  logic             q_push, q_pop, q_empty, q_full;
  logic [CNT_W-1:0] q_count;
  entry_t           q_din, q_head;
  logic             req_fire, resp_take;
  logic [CNT_W:0]   occupancy;

  ifetch_queue #(
    .DEPTH (MAX_INFLIGHT),
    .WIDTH ($bits(entry_t))
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .pop   (q_pop),
    .clear (flush),
    .din   (q_din),
    .head  (q_head),
    .count (q_count),
    .empty (q_empty),
    .full  (q_full)
  );

  // Credit: outstanding requests plus buffered words never exceed the queue
  // depth, so every response that is kept has a free slot waiting for it.
  assign occupancy     = {1'b0, inflight_q} + {1'b0, q_count};
  assign mem_req_valid = (state_q == RUN) && !flush && !rst &&
                         (occupancy < (CNT_W+1)'(MAX_INFLIGHT));
  assign mem_req_addr  = pc_q;
  assign req_fire      = mem_req_valid && mem_req_ready;
  assign resp_take     = mem_resp_valid && !flush && (drop_q == '0);

  assign stall_next            = q_empty || rst;
  assign q_pop                 = !stall_next && !next_stalled;
  assign instruction           = q_head.data;
  assign instruction_addr      = q_head.addr;
  assign instruction_next_addr = q_head.addr + `ALEN'(INSTR_BYTES);
  assign ifetch_exception      = q_head.fault;

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    misalign_d = 1'b0;
    q_push     = 1'b0;
    q_din      = '{data: mem_resp_data, fault: mem_resp_fault, addr: resp_pc_q};
    if (flush) begin
      // Every request still outstanding after this cycle is stale.
      pc_d       = flush_target;
      resp_pc_d  = flush_target;
      inflight_d = inflight_q - CNT_W'(mem_resp_valid);
      drop_d     = inflight_q - CNT_W'(mem_resp_valid);
      misalign_d = |flush_target[1:0];
      state_d    = misalign_d ? HALT : RUN;
    end else begin
      if (req_fire) pc_d = pc_q + `ALEN'(INSTR_BYTES);
      inflight_d = inflight_q + CNT_W'(req_fire) - CNT_W'(mem_resp_valid);
      if (mem_resp_valid && (drop_q != '0)) drop_d = drop_q - CNT_W'(1);
      // A misaligned redirect issues nothing, so no response can compete
      // with its synthetic exception entry for the queue write port.
      if (misalign_q) begin
        q_push = 1'b1;
        q_din  = '{data: '0, fault: 1'b1, addr: resp_pc_q};
      end else if (resp_take) begin
        q_push    = 1'b1;
        resp_pc_d = resp_pc_q + `ALEN'(INSTR_BYTES);
        if (mem_resp_fault) state_d = HALT;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      misalign_q <= misalign_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(resp_take && q_full && !q_pop));
  end

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: directed table of redirects, hand-written
// corner sequences and a randomized run, all checked against a queue-based
// reference of what decode should see and when fetches may be issued.
module tb_ifetch;

  localparam logic [31:0] RESET_PC = 32'h100;
  localparam int          MAX      = 2;

  logic        clk, rst, flush, next_stalled, mem_req_ready;
  logic        mem_resp_valid, mem_resp_fault;
  logic [31:0] flush_target, mem_resp_data;
  logic        stall_next, ifetch_exception, mem_req_valid;
  logic [31:0] instruction, instruction_addr, instruction_next_addr, mem_req_addr;

  ifetch #(.RESET_PC(RESET_PC), .MAX_INFLIGHT(MAX)) dut (
    .clk(clk), .rst(rst), .flush(flush), .flush_target(flush_target),
    .next_stalled(next_stalled), .stall_next(stall_next),
    .instruction(instruction), .instruction_addr(instruction_addr),
    .instruction_next_addr(instruction_next_addr), .ifetch_exception(ifetch_exception),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_fault(mem_resp_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; bit fault; bit dc; } ent_t;
  typedef struct {
    logic [31:0] target; int lat;
    logic [31:0] exp_addr0; bit exp_exc0; logic [31:0] exp_addr1;
    bit exp_req; logic [31:0] exp_req_addr;
  } vec_t;

  pend_t       pend[$];
  ent_t        mq[$];
  logic [31:0] m_pc, m_resp_addr, m_mis_addr;
  bit          m_halt, m_mis;
  int          stale_cnt;
  bit          fault_en;
  logic [31:0] fault_addr;
  bit          drv_rst, drv_flush, drv_stall, drv_ready;
  logic [31:0] drv_target;
  int          lat_fix;
  int          cyc, n_cmp, n_bad, n_req, n_deliv;
  bit          smp_stall, smp_resp;
  logic [31:0] smp_addr, smp_data;
  int          cap_n;
  logic [31:0] cap_addr [2];
  bit          cap_exc [2];
  bit          cap_req_seen, cap_exc_seen;
  logic [31:0] cap_req_addr, cap_exc_addr;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic bit is_fault(input logic [31:0] a);
    return fault_en && (a == fault_addr);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got %h, want %h", name, cyc, act, exp);
    end
  endtask

  task automatic drive_resp(input bit v, input logic [31:0] a);
    mem_resp_valid = v;
    mem_resp_data  = v ? memword(a) : 32'hDEAD_BEEF;
    mem_resp_fault = v && is_fault(a);
  endtask

  task automatic clr_cap();
    cap_n = 0; cap_req_seen = 0; cap_exc_seen = 0;
    cap_addr[0] = 32'hFFFF_FFFF; cap_addr[1] = 32'hFFFF_FFFF;
    cap_exc[0] = 0; cap_exc[1] = 0;
    cap_req_addr = 32'hFFFF_FFFF; cap_exc_addr = 32'hFFFF_FFFF;
  endtask

  // One clock cycle: drive, check against the reference, advance the reference.
  task automatic cycle();
    pend_t r;
    ent_t  e;
    bit    resp_now, exp_req, acc;
    int    l;
    resp_now = 0;
    r = '{addr: 32'h0, due: 0};
    rst = drv_rst; flush = drv_flush; flush_target = drv_target;
    next_stalled = drv_stall; mem_req_ready = drv_ready;
    if (!drv_rst && pend.size() > 0 && pend[0].due <= cyc) begin
      r = pend.pop_front();
      resp_now = 1;
    end
    drive_resp(resp_now, r.addr);
    #1;
    exp_req = !drv_rst && !drv_flush && !m_halt &&
              ((pend.size() + int'(resp_now) + mq.size()) < MAX);
    chk("req_valid", 32'(mem_req_valid), 32'(exp_req));
    if (exp_req && mem_req_valid) chk("req_addr", mem_req_addr, m_pc);
    chk("stall_next", 32'(stall_next), 32'(drv_rst || mq.size() == 0));
    if (!drv_rst && mq.size() > 0) begin
      e = mq[0];
      chk("instr_addr", instruction_addr, e.addr);
      chk("instr_next_addr", instruction_next_addr, e.addr + 32'd4);
      chk("exception", 32'(ifetch_exception), 32'(e.fault));
      if (!e.dc) chk("instruction", instruction, e.data);
    end
    smp_stall = stall_next; smp_addr = instruction_addr; smp_data = instruction;
    if (!drv_rst && !stall_next && !drv_stall) begin
      n_deliv++;
      if (cap_n < 2) begin
        cap_addr[cap_n] = instruction_addr;
        cap_exc[cap_n]  = ifetch_exception;
      end
      cap_n++;
      if (ifetch_exception && !cap_exc_seen) begin
        cap_exc_seen = 1; cap_exc_addr = instruction_addr;
      end
    end
    acc = !drv_rst && mem_req_valid && drv_ready;
    if (acc) begin
      n_req++;
      if (!cap_req_seen) begin cap_req_seen = 1; cap_req_addr = mem_req_addr; end
      l = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
      if (l == 0 && !resp_now && pend.size() == 0) begin
        resp_now = 1;
        drive_resp(1, mem_req_addr);
      end else begin
        pend.push_back('{addr: mem_req_addr, due: cyc + ((l < 1) ? 1 : l)});
      end
    end
    smp_resp = resp_now;
    if (drv_rst) begin
      mq.delete(); pend.delete();
      m_pc = RESET_PC; m_resp_addr = RESET_PC;
      m_halt = 0; m_mis = 0; stale_cnt = 0;
    end else if (drv_flush) begin
      mq.delete();
      stale_cnt   = pend.size();
      m_pc        = drv_target;
      m_resp_addr = drv_target;
      m_mis       = |drv_target[1:0];
      m_halt      = m_mis;
      m_mis_addr  = drv_target;
    end else begin
      if (mq.size() > 0 && !drv_stall) void'(mq.pop_front());
      if (resp_now) begin
        if (stale_cnt > 0) stale_cnt--;
        else begin
          mq.push_back('{addr: m_resp_addr, data: memword(m_resp_addr),
                         fault: is_fault(m_resp_addr), dc: 0});
          if (is_fault(m_resp_addr)) m_halt = 1;
          m_resp_addr += 32'd4;
        end
      end
      if (m_mis) begin
        mq.push_back('{addr: m_mis_addr, data: 32'h0, fault: 1, dc: 1});
        m_mis = 0;
      end
      if (acc) m_pc += 32'd4;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_flush(input logic [31:0] t);
    drv_flush = 1; drv_target = t;
    cycle();
    drv_flush = 0;
  endtask

  vec_t        tbl [6];
  int          stalls, n, reqs0, deliv0;
  bit          have_ref;
  logic [31:0] ref_addr, ref_data, t;

  initial begin
    tbl[0] = '{32'h0000_0400, 0, 32'h0000_0400, 0, 32'h0000_0404, 1, 32'h0000_0400};
    tbl[1] = '{32'h0000_0302, 0, 32'h0000_0302, 1, 32'h0,         0, 32'h0};
    tbl[2] = '{32'h0000_0300, 2, 32'h0000_0300, 0, 32'h0000_0304, 1, 32'h0000_0300};
    tbl[3] = '{32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 32'h0000_0000, 1, 32'hFFFF_FFFC};
    tbl[4] = '{32'h0000_0001, 0, 32'h0000_0001, 1, 32'h0,         0, 32'h0};
    tbl[5] = '{32'h8000_0010, 3, 32'h8000_0010, 0, 32'h8000_0014, 1, 32'h8000_0010};

    cyc = 0; n_cmp = 0; n_bad = 0; n_req = 0; n_deliv = 0;
    m_pc = RESET_PC; m_resp_addr = RESET_PC; m_mis_addr = 0;
    m_halt = 0; m_mis = 0; stale_cnt = 0; fault_en = 0; fault_addr = 0;
    drv_rst = 1; drv_flush = 0; drv_target = 0; drv_stall = 0; drv_ready = 1; lat_fix = 0;
    rst = 1; flush = 0; flush_target = 0; next_stalled = 0; mem_req_ready = 1;
    mem_resp_valid = 0; mem_resp_data = 0; mem_resp_fault = 0;
    clr_cap();
    @(posedge clk); #1;

    // Reset, then single-cycle memory: back-to-back delivery from RESET_PC.
    repeat (3) cycle();
    drv_rst = 0; clr_cap(); stalls = 0;
    for (int i = 0; i < 24; i++) begin
      cycle();
      if (i >= 1 && smp_stall) stalls++;
    end
    chk("t1_first_req", cap_req_addr, 32'h100);
    chk("t1_entry0", cap_addr[0], 32'h100);
    chk("t1_entry1", cap_addr[1], 32'h104);
    chk("t1_steady_stalls", 32'(stalls), 32'd0);

    // Decode backpressure for 5 cycles mid-stream.
    lat_fix = 1;
    repeat (6) cycle();
    drv_stall = 1; have_ref = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t2_inflight_max", 32'(pend.size() <= MAX), 32'd1);
      if (have_ref) begin
        chk("t2_hold_valid", 32'(smp_stall), 32'd0);
        chk("t2_hold_addr", smp_addr, ref_addr);
        chk("t2_hold_data", smp_data, ref_data);
      end else if (!smp_stall) begin
        have_ref = 1; ref_addr = smp_addr; ref_data = smp_data;
      end
    end
    chk("t2_ref_seen", 32'(have_ref), 32'd1);
    drv_stall = 0;
    repeat (10) cycle();

    // Two requests outstanding, then redirect: both responses are stale.
    lat_fix = 3;
    do_flush(32'h200);
    n = 0;
    while (pend.size() < 2 && n < 10) begin cycle(); n++; end
    chk("t3_two_inflight", 32'(pend.size()), 32'd2);
    if (pend.size() == 2) begin
      chk("t3_req0", pend[0].addr, 32'h200);
      chk("t3_req1", pend[1].addr, 32'h204);
    end
    do_flush(32'h400);
    clr_cap();
    repeat (15) cycle();
    chk("t3_after_flush", cap_addr[0], 32'h400);

    // Redirect in the same cycle a response arrives.
    lat_fix = 2;
    do_flush(32'h500);
    n = 0;
    while (!(pend.size() > 0 && pend[0].due <= cyc) && n < 10) begin cycle(); n++; end
    do_flush(32'h600);
    chk("t4_resp_in_flush", 32'(smp_resp), 32'd1);
    clr_cap();
    repeat (15) cycle();
    chk("t4_entry0", cap_addr[0], 32'h600);
    chk("t4_entry1", cap_addr[1], 32'h604);

    // Access fault on 'h108 halts fetching until the next redirect.
    lat_fix = 0; fault_en = 1; fault_addr = 32'h108;
    do_flush(32'h100);
    clr_cap();
    n = 0;
    while (!cap_exc_seen && n < 30) begin cycle(); n++; end
    chk("t5_fault_seen", 32'(cap_exc_seen), 32'd1);
    chk("t5_fault_addr", cap_exc_addr, 32'h108);
    reqs0 = n_req;
    repeat (10) cycle();
    chk("t5_no_req_halted", 32'(n_req - reqs0), 32'd0);
    fault_en = 0;

    // Redirect table, including misaligned targets and PC wrap.
    for (int v = 0; v < 6; v++) begin
      lat_fix = tbl[v].lat;
      do_flush(tbl[v].target);
      clr_cap();
      repeat (20) cycle();
      chk($sformatf("v%0d_addr0", v), cap_addr[0], tbl[v].exp_addr0);
      chk($sformatf("v%0d_exc0", v), 32'(cap_exc[0]), 32'(tbl[v].exp_exc0));
      if (tbl[v].exp_exc0) chk($sformatf("v%0d_count", v), 32'(cap_n), 32'd1);
      else chk($sformatf("v%0d_addr1", v), cap_addr[1], tbl[v].exp_addr1);
      chk($sformatf("v%0d_req_seen", v), 32'(cap_req_seen), 32'(tbl[v].exp_req));
      if (tbl[v].exp_req) chk($sformatf("v%0d_req_addr", v), cap_req_addr, tbl[v].exp_req_addr);
    end

    // Randomized traffic, backpressure, redirects, faults and one reset.
    lat_fix = -1;
    deliv0 = n_deliv;
    for (int i = 0; i < 3000; i++) begin
      drv_rst   = (i >= 1500 && i < 1502);
      drv_stall = ($urandom_range(0, 3) == 0);
      drv_ready = ($urandom_range(0, 4) != 0);
      drv_flush = ($urandom_range(0, 39) == 0);
      if (drv_flush) begin
        t = 32'($urandom_range(0, 1023)) << 2;
        if ($urandom_range(0, 7) == 0) t[1:0] = 2'($urandom_range(1, 3));
        drv_target = t;
        fault_en = ($urandom_range(0, 1) == 1);
        fault_addr = {t[31:2], 2'b00} + 32'(4 * $urandom_range(0, 7));
      end
      cycle();
    end
    drv_flush = 0; drv_stall = 0; drv_rst = 0;
    chk("random_deliveries", 32'((n_deliv - deliv0) > 300), 32'd1);

    drv_rst = 1;
    repeat (2) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
